// File: rtl/wb_stage_multi.sv
// Multi-lane writeback stage: load formatting, regfile write ports and debug trace port.
// Define WB_TRACE_EN to serialise retirements through a trace FIFO; otherwise lane 0 drives the debug port.
module wb_stage_multi #(
    parameter int LANES       = 2,
    parameter int TRACE_DEPTH = 8,
    parameter int MOP_W       = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wb_stall_i,
    input  logic                   wb_flush_i,
    input  logic [LANES-1:0]       wb_valid_i,
    input  logic [LANES*MOP_W-1:0] wb_memop_i,
    input  logic [LANES-1:0]       wb_wren_i,
    input  logic [LANES*5-1:0]     wb_waddr_i,
    input  logic [LANES*32-1:0]    wb_wdata_i,
    input  logic [LANES*32-1:0]    wb_mem_addr_i,
    input  logic [LANES*32-1:0]    wb_mem_data_i,
    input  logic [LANES*32-1:0]    wb_pc_i,
    output logic [LANES-1:0]       wb_wren_o,
    output logic [LANES*5-1:0]     wb_waddr_o,
    output logic [LANES*32-1:0]    wb_wdata_o,
    output logic                   wb_stall_req_o,
    output logic                   trace_ovf_o,
    output logic [31:0]            debug_wb_pc,
    output logic [3:0]             debug_wb_rf_wen,
    output logic [4:0]             debug_wb_rf_wnum,
    output logic [31:0]            debug_wb_rf_wdata
);

    localparam logic [MOP_W-1:0] MOP_LB  = MOP_W'(1);
    localparam logic [MOP_W-1:0] MOP_LBU = MOP_W'(2);
    localparam logic [MOP_W-1:0] MOP_LH  = MOP_W'(3);
    localparam logic [MOP_W-1:0] MOP_LHU = MOP_W'(4);
    localparam logic [MOP_W-1:0] MOP_LW  = MOP_W'(5);

    // Little-endian extraction; unknown memops fall back to the ALU result.
    function automatic logic [31:0] format_result(
        input logic [MOP_W-1:0] memop,
        input logic [1:0]       off,
        input logic [31:0]      word,
        input logic [31:0]      alu
    );
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        byte_v = word[{off, 3'b000} +: 8];
        half_v = off[1] ? word[31:16] : word[15:0];
        case (memop)
            MOP_LB:  format_result = {{24{byte_v[7]}}, byte_v};
            MOP_LBU: format_result = {24'h0, byte_v};
            MOP_LH:  format_result = {{16{half_v[15]}}, half_v};
            MOP_LHU: format_result = {16'h0, half_v};
            MOP_LW:  format_result = word;
            default: format_result = alu;
        endcase
    endfunction

    logic [4:0]  lane_waddr [LANES];
    logic [31:0] lane_data  [LANES];

    // NOTE: combinational blocks use blocking '=' and assign every output up front, so no latch can form.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_waddr[i] = wb_waddr_i[i*5 +: 5];
            lane_data[i]  = format_result(wb_memop_i[i*MOP_W +: MOP_W], wb_mem_addr_i[i*32 +: 2],
                                          wb_mem_data_i[i*32 +: 32], wb_wdata_i[i*32 +: 32]);
        end
    end

    logic             capture;
    logic [LANES-1:0] s_valid;
    logic [LANES-1:0] s_wren;
    logic [4:0]       s_waddr [LANES];
    logic [31:0]      s_wdata [LANES];

    assign capture = ~wb_flush_i & ~wb_stall_i;

    // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_valid <= '0;
            s_wren  <= '0;
            for (int i = 0; i < LANES; i++) begin
                s_waddr[i] <= '0;
                s_wdata[i] <= '0;
            end
        end else if (wb_flush_i) begin
            s_valid <= '0;
        end else if (!wb_stall_i) begin
            s_valid <= wb_valid_i;
            s_wren  <= wb_wren_i;
            for (int i = 0; i < LANES; i++) begin
                s_waddr[i] <= lane_waddr[i];
                s_wdata[i] <= lane_data[i];
            end
        end
    end

    always_comb begin
        wb_wren_o  = '0;
        wb_waddr_o = '0;
        wb_wdata_o = '0;
        for (int i = 0; i < LANES; i++) begin
            wb_wren_o[i]           = s_valid[i] & s_wren[i] & (s_waddr[i] != 5'd0);
            wb_waddr_o[i*5 +: 5]   = s_waddr[i];
            wb_wdata_o[i*32 +: 32] = s_wdata[i];
        end
    end

    logic unused;

`ifdef WB_TRACE_EN
    localparam int PTR_W = $clog2(TRACE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic        wen;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } trace_t;

    trace_t           mem [TRACE_DEPTH];
    trace_t           entry [LANES];
    trace_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] slot [LANES];
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] free;
    logic [CNT_W-1:0] n_push;
    logic [LANES-1:0] store;
    logic             pop;
    logic             ovf_set;

    assign pop  = (count != '0);
    // The entry popped this edge frees its slot for a simultaneous push.
    assign free = CNT_W'(TRACE_DEPTH) - count + CNT_W'(pop);

    always_comb begin
        n_push  = '0;
        ovf_set = 1'b0;
        store   = '0;
        for (int i = 0; i < LANES; i++) begin
            entry[i].pc    = wb_pc_i[i*32 +: 32];
            entry[i].wen   = wb_wren_i[i] & (lane_waddr[i] != 5'd0);
            entry[i].wnum  = lane_waddr[i];
            entry[i].wdata = lane_data[i];
            slot[i]        = wr_ptr + n_push[PTR_W-1:0];
            if (capture && wb_valid_i[i]) begin
                if (n_push < free) begin
                    store[i] = 1'b1;
                    n_push   = n_push + CNT_W'(1);
                end else begin
                    ovf_set = 1'b1;
                end
            end
        end
    end

    // NOTE: trace storage has no reset; the occupancy count gates every read, so stale entries stay invisible.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (store[i]) mem[slot[i]] <= entry[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            trace_ovf_o <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + n_push[PTR_W-1:0];
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + n_push - CNT_W'(pop);
            if (ovf_set) trace_ovf_o <= 1'b1;
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        debug_wb_pc       = '0;
        debug_wb_rf_wen   = '0;
        debug_wb_rf_wnum  = '0;
        debug_wb_rf_wdata = '0;
        if (pop) begin
            debug_wb_pc       = head.pc;
            debug_wb_rf_wen   = {4{head.wen}};
            debug_wb_rf_wnum  = head.wnum;
            debug_wb_rf_wdata = head.wdata;
        end
    end

    assign wb_stall_req_o = (CNT_W'(TRACE_DEPTH) - count) < CNT_W'(LANES);
    assign unused         = ^wb_mem_addr_i;
`else
    logic [31:0] s_pc0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       s_pc0 <= '0;
        else if (capture) s_pc0 <= wb_pc_i[31:0];
    end

    assign debug_wb_pc       = s_pc0;
    assign debug_wb_rf_wen   = {4{wb_wren_o[0]}};
    assign debug_wb_rf_wnum  = s_waddr[0];
    assign debug_wb_rf_wdata = s_wdata[0];
    assign wb_stall_req_o    = 1'b0;
    assign trace_ovf_o       = 1'b0;
    assign unused            = ^{wb_mem_addr_i, wb_pc_i, 32'(TRACE_DEPTH)};
`endif

endmodule
